// File: rtl/dmem_mmio.sv
// Data-side memory responder: word RAM plus MMIO (cycle counter, console TX FIFO, status).
// Optional feature macro: DMEM_CYCLE_COUNTER_EN enables the CYCLE counter register.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        conValid,
  output logic [7:0]  conData,
  input  logic        conReady
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   ram      [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          sel_mmio;
  logic          wr_ram, wr_cycle, wr_tx, wr_status;
  logic          fifo_empty, fifo_full;
  logic          pop, push_ok;
  logic [31:0]   cycle_rd;
  logic [31:0]   status_rd;
  logic          unused_addr;

  assign sel_mmio  = addr[31];
  assign wr_ram    = memWrite & ~sel_mmio;
  assign wr_cycle  = memWrite & sel_mmio & (addr[3:2] == 2'd0);
  assign wr_tx     = memWrite & sel_mmio & (addr[3:2] == 2'd1);
  assign wr_status = memWrite & sel_mmio & (addr[3:2] == 2'd2);

  // Upper RAM address bits alias; byte offset is ignored.
  assign unused_addr = ^{addr[30:AW+2], addr[1:0]};

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign conValid   = ~fifo_empty;
  assign conData    = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign pop     = conValid & conReady;
  assign push_ok = wr_tx & (~fifo_full | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    if (wr_tx & ~push_ok)           ovf_d = 1'b1;
    if (wr_status & writeData[2])   ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage arrays carry no reset; occupancy gating hides stale FIFO bytes.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= writeData[7:0];
  end

  always_ff @(posedge clk) begin
    if (wr_ram) ram[addr[AW+1:2]] <= writeData;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q, cycle_d;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (wr_cycle) cycle_d = writeData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end

  assign cycle_rd = cycle_q;
`else
  logic unused_cycle;
  assign unused_cycle = wr_cycle;
  assign cycle_rd     = '0;
`endif

  assign status_rd = {16'h0000, 8'(count_q), 5'b00000, ovf_q, fifo_full, fifo_empty};

  always_comb begin
    readData = '0;
    if (!sel_mmio) begin
      readData = ram[addr[AW+1:2]];
    end else begin
      case (addr[3:2])
        2'd0:    readData = cycle_rd;
        2'd1:    readData = {24'h000000, conData};
        2'd2:    readData = status_rd;
        default: readData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus randomized traffic against a queue-based model.
module tb_dmem_mmio;

  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] A_TX     = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] writeData = '0;
  logic        conReady = 1'b0;
  logic [31:0] readData;
  logic        conValid;
  logic [7:0]  conData;

  always #5 clk = ~clk;

  dmem_mmio #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .memWrite(memWrite),
    .addr(addr),
    .writeData(writeData),
    .readData(readData),
    .conValid(conValid),
    .conData(conData),
    .conReady(conReady)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [7:0]  mq[$];
  logic [31:0] ram_m [RAM_WORDS];
  bit          ram_ok [RAM_WORDS];
  logic        ovf_m = 1'b0;
  logic [31:0] cyc_m = '0;
  logic [7:0]  obs[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [7:0] model_head();
    return (mq.size() != 0) ? mq[0] : 8'h00;
  endfunction

  task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    int idx;
    known = 1'b1;
    v = '0;
    if (!a[31]) begin
      idx = (a >> 2) % RAM_WORDS;
      known = ram_ok[idx];
      v = ram_m[idx];
    end else begin
      case (a[3:2])
        2'd0: begin
`ifdef DMEM_CYCLE_COUNTER_EN
          v = cyc_m;
`else
          v = '0;
`endif
        end
        2'd1: v = {24'h0, model_head()};
        2'd2: v = {16'h0, 8'(mq.size()), 5'b0, ovf_m,
                   1'(mq.size() == FIFO_DEPTH), 1'(mq.size() == 0)};
        default: v = '0;
      endcase
    end
  endtask

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    bit do_pop, is_tx, accept;
    do_pop = (mq.size() != 0) && rdy;
    is_tx  = we && a[31] && (a[3:2] == 2'd1);
    accept = is_tx && ((mq.size() < FIFO_DEPTH) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (accept) mq.push_back(wd[7:0]);
    else if (is_tx) ovf_m = 1'b1;
    if (we && a[31] && (a[3:2] == 2'd2) && wd[2]) ovf_m = 1'b0;
`ifdef DMEM_CYCLE_COUNTER_EN
    if (we && a[31] && (a[3:2] == 2'd0)) cyc_m = wd;
    else cyc_m = cyc_m + 32'd1;
`endif
    if (we && !a[31]) begin
      ram_m[(a >> 2) % RAM_WORDS]  = wd;
      ram_ok[(a >> 2) % RAM_WORDS] = 1'b1;
    end
  endtask

  // Called just after a rising edge; drives one cycle, checks at the falling edge, advances the model.
  task automatic cycle_io(input string tag, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic rdy);
    logic [31:0] exp_rd;
    bit known;
    memWrite = we; addr = a; writeData = wd; conReady = rdy;
    @(negedge clk);
    model_read(a, exp_rd, known);
    if (known) check_eq({tag, "_rd"}, readData, exp_rd);
    check_eq({tag, "_valid"}, 32'(conValid), 32'(mq.size() != 0));
    check_eq({tag, "_data"}, 32'(conData), 32'(model_head()));
    if (conValid && rdy) obs.push_back(conData);
    @(posedge clk);
    model_edge(we, a, wd, rdy);
    #1;
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [7:0]  exp_order [5];
    int r;
    exp_order[0] = 8'h41; exp_order[1] = 8'h42; exp_order[2] = 8'h43;
    exp_order[3] = 8'h44; exp_order[4] = 8'h46;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    addr = A_STATUS; #1;
    check_eq("rst_status", readData, 32'h0000_0001);
    check_eq("rst_valid", 32'(conValid), 32'h0);
    check_eq("rst_data", 32'(conData), 32'h0);
    addr = A_CYCLE; #1;
    check_eq("rst_cycle", readData, 32'h0);
    addr = A_TX; #1;
    check_eq("rst_txdata", readData, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_edge(1'b0, '0, '0, 1'b0);
    #1;

    // RAM store, readback and aliasing
    cycle_io("ram_wr", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    cycle_io("ram_rd", 1'b0, 32'h0000_0010, '0, 1'b0);
    cycle_io("ram_alias", 1'b0, 32'h0000_0110, '0, 1'b0);
    cycle_io("ram_alias_off", 1'b0, 32'h0000_0113, '0, 1'b0);

    // counter idle, load and wrap
    repeat (2) cycle_io("idle", 1'b0, A_CYCLE, '0, 1'b0);
    cycle_io("cyc_rd", 1'b0, A_CYCLE, '0, 1'b0);
    cycle_io("cyc_load", 1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0);
    cycle_io("cyc_p1", 1'b0, A_CYCLE, '0, 1'b0);
    cycle_io("cyc_p2", 1'b0, A_CYCLE, '0, 1'b0);
    cycle_io("cyc_wrap", 1'b0, A_CYCLE, '0, 1'b0);

    // fill, overflow, clear
    for (int i = 0; i < 4; i++) cycle_io("push", 1'b1, A_TX, 32'h41 + i, 1'b0);
    cycle_io("st_full", 1'b0, A_STATUS, '0, 1'b0);
    cycle_io("push_ovf", 1'b1, A_TX, 32'h45, 1'b0);
    cycle_io("st_ovf", 1'b0, A_STATUS, '0, 1'b0);
    cycle_io("tx_head", 1'b0, A_TX, '0, 1'b0);
    cycle_io("st_clr", 1'b1, A_STATUS, 32'h4, 1'b0);
    cycle_io("st_after_clr", 1'b0, A_STATUS, '0, 1'b0);

    // simultaneous push and pop on a full FIFO
    obs.delete();
    cycle_io("full_pushpop", 1'b1, A_TX, 32'h46, 1'b1);
    repeat (5) cycle_io("drain", 1'b0, A_STATUS, '0, 1'b1);
    check_eq("drain_cnt", 32'(obs.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < obs.size()) check_eq("drain_order", 32'(obs[i]), 32'(exp_order[i]));

    // reset while bytes are queued
    for (int i = 0; i < 3; i++) cycle_io("push3", 1'b1, A_TX, 32'h51 + i, 1'b0);
    memWrite = 1'b0;
    addr = A_TX;
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(conValid), 32'h0);
    check_eq("async_rst_data", 32'(conData), 32'h0);
    check_eq("async_rst_tx", readData, 32'h0);
    mq.delete();
    ovf_m = 1'b0;
    cyc_m = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_edge(1'b0, '0, '0, 1'b0);
    #1;
    cycle_io("post_rst_status", 1'b0, A_STATUS, '0, 1'b0);
    cycle_io("post_rst_cycle", 1'b0, A_CYCLE, '0, 1'b0);
    cycle_io("post_rst_ram", 1'b0, 32'h0000_0010, '0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 9);
      a  = $urandom;
      wd = $urandom;
      case (r)
        0, 1, 2: begin
          a[31] = 1'b0; a[7:2] = 6'($urandom_range(0, 7));
          cycle_io("rnd_ramw", 1'b1, a, wd, 1'($urandom_range(0, 1)));
        end
        3, 4: begin
          a[31] = 1'b0; a[7:2] = 6'($urandom_range(0, 7));
          cycle_io("rnd_ramr", 1'b0, a, wd, 1'($urandom_range(0, 1)));
        end
        5, 6: begin
          a[31] = 1'b1; a[3:2] = 2'd1;
          cycle_io("rnd_push", 1'b1, a, wd, 1'($urandom_range(0, 1)));
        end
        7: begin
          a[31] = 1'b1; a[3:2] = 2'd2;
          cycle_io("rnd_stw", 1'b1, a, wd, 1'($urandom_range(0, 1)));
        end
        8: begin
          a[31] = 1'b1;
          cycle_io("rnd_mmr", 1'b0, a, wd, 1'($urandom_range(0, 1)));
        end
        default: begin
          a[31] = 1'b1; a[3:2] = 2'($urandom_range(0, 1) * 3);
          cycle_io("rnd_cycw", 1'b1, a, wd, 1'($urandom_range(0, 1)));
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory responder for the single-cycle CPU: answers the CPU's data port (address, write data, write enable, read data) with a word-addressed RAM plus a small memory-mapped I/O region. The MMIO region holds a free-running cycle counter and a byte-wide console transmit FIFO drained through a valid/ready handshake. It sits beside the CPU in the top level, with the CPU's `aluOut`, `writeData`, `memWrite` and `readData` wired to `addr`, `writeData`, `memWrite` and `readData` here.

## Interface
- `RAM_WORDS`, 64: RAM depth in 32-bit words; power of two. `AW` = log2(`RAM_WORDS`).
- `FIFO_DEPTH`, 4: console FIFO depth in bytes; power of two, at least 2.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state except RAM contents.
- `memWrite` input 1: write strobe for the current `addr`.
- `addr` input 32: byte address; bits [1:0] are ignored.
- `writeData` input 32: store data.
- `readData` output 32: combinational load data for `addr`.
- `conValid` output 1: FIFO non-empty; `conData` is valid.
- `conData` output 8: FIFO head byte; 8'h00 when empty.
- `conReady` input 1: sink accepts the head byte this cycle.

## Operation
- Decode:
  - `addr[31]`=0 selects RAM. Index is `addr[AW+1:2]`; upper bits alias.
  - `addr[31]`=1 selects MMIO. Decode uses `addr[3:2]` only.
- RAM:
  - Write `writeData` on the clock edge when `memWrite`=1.
  - Read is combinational.
  - Not cleared by `reset`.
- MMIO word 0, CYCLE (0x80000000):
  - 32-bit counter, increments every cycle and wraps 0xFFFFFFFF→0.
  - Read returns the current count.
  - A write loads `writeData`. There is no increment on the load edge.
- MMIO word 1, TXDATA (0x80000004):
  - A write pushes `writeData[7:0]`.
  - Read returns {24'b0, head byte}, or 0 if empty. Reads never pop.
- MMIO word 2, STATUS (0x80000008):
  - Read returns: bit0 empty, bit1 full, bit2 overflow, bits[15:8] occupancy count, all other bits 0.
  - A write with `writeData[2]`=1 clears overflow. Other bits are ignored.
- MMIO word 3 (0x8000000C): reserved. Reads 0, writes ignored.
- FIFO:
  - Pop on an edge where `conValid`&`conReady`.
  - A push is accepted if not full, or if a pop occurs on the same edge.
  - When full with a simultaneous pop and push, the count is unchanged and the new byte goes to the tail.
  - A push to a full FIFO with no pop is dropped and sets sticky overflow. FIFO contents are unchanged.
  - An overflow-set event and a STATUS clear on the same edge cannot coincide, because both are writes to different addresses.
  - Read/write pointers wrap modulo `FIFO_DEPTH`. The count is held separately, so full and empty are distinguished.
- Reset values:
  - CYCLE = 0, FIFO empty, overflow = 0.
  - `conValid` = 0, `conData` = 8'h00.
  - `readData` follows `addr` combinationally: RAM contents for RAM addresses; for MMIO, the reset values above.

## Timing
- Load latency is 0 cycles; `readData` is combinational from `addr` and state.
- Stores: a RAM store is visible to reads from the cycle after its edge.
- TXDATA push: `conValid` rises the cycle after the push edge when the FIFO was previously empty.
- Pop: head advances on the handshake edge. `conData`/`conValid` reflect the new head the next cycle.
- Asserting `reset` mid-transfer:
  - Drops all queued bytes and deasserts `conValid` immediately, without waiting for a clock.
  - The counter returns to 0 on release and increments from the first edge after release.

## Configuration
- `DMEM_CYCLE_COUNTER_EN`:
  - Defined: CYCLE behaves as above.
  - Undefined: no counter register exists; CYCLE reads 0 and writes to it are ignored. All other behaviour is identical.

## Test plan
- Reset, then `memWrite`=1, `addr`=0x00000010, data 0xDEADBEEF; next cycle read 0x10 → 0xDEADBEEF; read 0x00000110 with `RAM_WORDS`=64 → 0xDEADBEEF (alias).
- Release reset, idle 5 cycles, read 0x80000000 → 5. Write 0xFFFFFFFE, wait 2 cycles, read → 0x00000000 (wrap).
- `conReady`=0; push 0x41,0x42,0x43,0x44 → STATUS = 0x00000402 (count 4, full). Push 0x45 → STATUS = 0x00000406. Write STATUS 0x4 → 0x00000402.
- With full FIFO and `conReady`=1, push 0x46 in the same cycle → 4 pops then 0x46 emerges: output order 0x41,0x42,0x43,0x44,0x46. Overflow stays 0.
- Push 3 bytes with `conReady`=0, assert `reset` between edges → `conValid`=0 and `conData`=0 immediately. After release STATUS = 0x00000001 and RAM data is retained.
- Build without `DMEM_CYCLE_COUNTER_EN`: idle 10 cycles, read 0x80000000 → 0; write 0x1234 then read → 0.
